// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } md_state_e;

  localparam int ITERS = 32;
  localparam int CNT_W = $clog2(ITERS);

endpackage

// File: rtl/muldiv_ctrl.sv
// MIPS32 EX-stage mul/div sequencer: 32 shift-add / restoring shift-subtract
// iterations on magnitudes, then one sign-fix cycle that commits HI/LO.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            flush,
  input  logic            wr_hi,
  input  logic            wr_lo,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  function automatic logic [XLEN-1:0] neg32(input logic [XLEN-1:0] x);
    return ~x + 1'b1;
  endfunction

  function automatic logic [2*XLEN-1:0] neg64(input logic [2*XLEN-1:0] x);
    return ~x + 1'b1;
  endfunction

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // acc holds {partial product, multiplier} for mul, {remainder, quotient} for div
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic              isdiv_q, isdiv_d;
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic              divz_q, divz_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic              done_q, done_d;

  logic [XLEN:0]     msum, rsh, diff;
  logic [2*XLEN-1:0] prod;
  logic              sgn, a_neg, b_neg;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    isdiv_d = isdiv_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    divz_d  = divz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    msum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + ({(XLEN+1){acc_q[0]}} & {1'b0, b_q});
    rsh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff  = rsh - {1'b0, b_q};
    prod  = neg_q ? neg64(acc_q) : acc_q;
    sgn   = (op == OP_MULT) || (op == OP_DIV);
    a_neg = sgn & rs_val[XLEN-1];
    b_neg = sgn & rt_val[XLEN-1];

    unique case (state_q)
      S_IDLE: begin
        if (wr_hi) hi_d = wdata;
        if (wr_lo) lo_d = wdata;
        if (start && !flush) begin
          state_d = S_RUN;
          cnt_d   = CNT_W'(ITERS - 1);
          acc_d   = {{XLEN{1'b0}}, a_neg ? neg32(rs_val) : rs_val};
          b_d     = b_neg ? neg32(rt_val) : rt_val;
          isdiv_d = op[1];
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          divz_d  = (rt_val == '0);
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = S_FIX;
          if (!isdiv_q)
            acc_d = {msum, acc_q[XLEN-1:1]};
          else if (diff[XLEN])
            acc_d = {rsh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
          else
            acc_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (!isdiv_q) begin
            hi_d = prod[2*XLEN-1:XLEN];
            lo_d = prod[XLEN-1:0];
          end else begin
            // remainder magnitude already equals |rs| on divide-by-zero,
            // so only the quotient needs the override
            hi_d = rneg_q ? neg32(acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
            lo_d = divz_q ? '1 : (neg_q ? neg32(acc_q[XLEN-1:0]) : acc_q[XLEN-1:0]);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      isdiv_q <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      divz_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      isdiv_q <= isdiv_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      divz_q  <= divz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
